tt_spine_ctrl: RTL

- Root-end controller for the vertical spine. It drives the spine inward word: user inputs, the 10-bit design select, enable and guards.
- It collects the spine outward word and presents the selected design's outputs to the pads.
- It owns selection sequencing: the select counter, break-before-make enable gating and settle timing. This guarantees at most one user module is enabled and that row/column tri-state buffers never switch while enabled.
- Sits at the top/bottom of the spine, between the pad ring and the row muxes.

---
 rtl/tt_spine_ctrl_pkg.sv | 53 +++++
 rtl/tt_spine_ctrl_if.sv | 21 ++
 rtl/tt_ctrl_sync.sv | 47 ++++
 rtl/tt_spine_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tt_spine_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_spine_ctrl_pkg                                                          |
// | Shared widths, spine field offsets, FSM states and select arithmetic.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef TT_N_I
`define TT_N_I 10
`endif
`ifndef TT_N_O
`define TT_N_O 8
`endif
`ifndef TT_N_IO
`define TT_N_IO 8
`endif

package tt_spine_ctrl_pkg;

    localparam int c_n_i   = `TT_N_I;
    localparam int c_n_o   = `TT_N_O;
    localparam int c_n_io  = `TT_N_IO;
    localparam int c_sel_w = 10;
    localparam int c_cnt_w = 4;

    // Inward word, LSB first: gl, ena, sel, usr, gh.  Outward: gl, usr, gh.
    localparam int c_iw_ena     = 1;
    localparam int c_iw_sel_lsb = 2;
    localparam int c_iw_usr_lsb = c_iw_sel_lsb + c_sel_w;
    localparam int c_ow_usr_lsb = 1;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DROP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ON     = 2'd3
    } state_t;

    // Select reset beats increment; increment wraps naturally at 10 bits.
    function automatic logic [c_sel_w-1:0] sel_next(input logic [c_sel_w-1:0] sel,
                                                     input logic do_rst,
                                                     input logic do_inc);
        if (do_rst)
            return '0;
        else if (do_inc)
            return sel + c_sel_w'(1);
        else
            return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tt_spine_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_spine_ctrl_if                                                           |
// | Spine inward/outward word bundle between root controller and row muxes.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

interface tt_spine_ctrl_if
    import tt_spine_ctrl_pkg::*;
#(
    parameter int S_IW = c_n_i + c_n_io + 13,
    parameter int S_OW = c_n_o + 2 * c_n_io + 2
);
    logic [S_IW-1:0] spine_iw;
    logic [S_OW-1:0] spine_ow;

    modport master (output spine_iw, input spine_ow);
    modport slave  (input spine_iw, output spine_ow);
endinterface

`default_nettype wire

// File: rtl/tt_ctrl_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_ctrl_sync                                                               |
// | Two-flop synchronizer; EDGE=1 turns the output into a rising-edge pulse.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tt_ctrl_sync #(
    parameter bit EDGE = 1'b0
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic r_prev;
            always_ff @(posedge clk) begin
                if (rst)
                    r_prev <= 1'b0;
                else
                    r_prev <= r_sync;
            end
            assign q = r_sync & ~r_prev;
        end else begin : g_level
            assign q = r_sync;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tt_spine_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_spine_ctrl                                                              |
// | Root-end spine controller: select sequencing, enable gating, pad muxing.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tt_spine_ctrl
    import tt_spine_ctrl_pkg::*;
#(
    parameter int N_I        = c_n_i,
    parameter int N_O        = c_n_o,
    parameter int N_IO       = c_n_io,
    parameter int SETTLE_CYC = 4,
    parameter int S_OW       = N_O + 2 * N_IO + 2,
    parameter int S_IW       = N_I + N_IO + 13
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               ctrl_sel_rst,
    input  wire               ctrl_sel_inc,
    input  wire               ctrl_ena,
    input  wire  [N_I-1:0]    pad_ui_in,
    input  wire  [N_IO-1:0]   pad_uio_in,
    output logic [N_O-1:0]    pad_uo_out,
    output logic [N_IO-1:0]   pad_uio_out,
    output logic [N_IO-1:0]   pad_uio_oe,
    tt_spine_ctrl_if.master   spine,
    output logic [c_sel_w-1:0] cur_sel,
    output logic              active
);

    localparam int c_usr_iw_w = N_I + N_IO;
    localparam int c_usr_ow_w = N_O + 2 * N_IO;
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(SETTLE_CYC - 1);

    logic w_sel_rst;
    logic w_inc;
    logic w_ena_req;
    logic w_chg;

    state_t              r_state, w_state_nx;
    logic [c_sel_w-1:0]  r_sel, w_sel_nx;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nx;
    logic                r_pend_rst, w_pend_rst_nx;
    logic                r_pend_inc, w_pend_inc_nx;

    logic [c_usr_iw_w-1:0] r_usr_iw;
    logic [c_usr_ow_w-1:0] w_usr_ow;
    logic [S_IW-1:0]       w_iw;
    logic                  w_unused_guards;

    tt_ctrl_sync #(.EDGE(1'b0)) u_sync_rst (.clk(clk), .rst(rst), .d(ctrl_sel_rst), .q(w_sel_rst));
    tt_ctrl_sync #(.EDGE(1'b1)) u_sync_inc (.clk(clk), .rst(rst), .d(ctrl_sel_inc), .q(w_inc));
    tt_ctrl_sync #(.EDGE(1'b0)) u_sync_ena (.clk(clk), .rst(rst), .d(ctrl_ena),     .q(w_ena_req));

    assign w_chg = w_sel_rst | w_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_sel      <= '0;
            r_cnt      <= '0;
            r_pend_rst <= 1'b0;
            r_pend_inc <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sel      <= w_sel_nx;
            r_cnt      <= w_cnt_nx;
            r_pend_rst <= w_pend_rst_nx;
            r_pend_inc <= w_pend_inc_nx;
        end
    end

    // sel only moves outside ON, and never during the DROP cycle itself:
    // a change seen in ON is parked and applied on the DROP->SETTLE edge.
    always_comb begin
        w_state_nx    = r_state;
        w_sel_nx      = r_sel;
        w_cnt_nx      = r_cnt;
        w_pend_rst_nx = r_pend_rst;
        w_pend_inc_nx = r_pend_inc;
        case (r_state)
            ST_OFF: begin
                if (w_chg) begin
                    w_sel_nx   = sel_next(r_sel, w_sel_rst, w_inc);
                    w_state_nx = ST_SETTLE;
                    w_cnt_nx   = c_reload;
                end else if (w_ena_req) begin
                    w_state_nx = ST_SETTLE;
                    w_cnt_nx   = c_reload;
                end
            end
            ST_ON: begin
                if (w_chg) begin
                    w_state_nx    = ST_DROP;
                    w_pend_rst_nx = w_sel_rst;
                    w_pend_inc_nx = w_inc;
                end else if (!w_ena_req) begin
                    w_state_nx = ST_OFF;
                end
            end
            ST_DROP: begin
                w_sel_nx      = sel_next(r_sel, r_pend_rst | w_sel_rst, r_pend_inc | w_inc);
                w_pend_rst_nx = 1'b0;
                w_pend_inc_nx = 1'b0;
                w_state_nx    = ST_SETTLE;
                w_cnt_nx      = c_reload;
            end
            ST_SETTLE: begin
                if (w_chg) begin
                    w_sel_nx = sel_next(r_sel, w_sel_rst, w_inc);
                    w_cnt_nx = c_reload;
                end else if (r_cnt == '0) begin
                    w_state_nx = w_ena_req ? ST_ON : ST_OFF;
                end else begin
                    w_cnt_nx = r_cnt - c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nx = ST_OFF;
            end
        endcase
    end

    assign active  = (r_state == ST_ON);
    assign cur_sel = r_sel;

    assign w_usr_ow        = spine.spine_ow[c_ow_usr_lsb +: c_usr_ow_w];
    assign w_unused_guards = spine.spine_ow[0] ^ spine.spine_ow[S_OW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_usr_iw    <= '0;
            pad_uo_out  <= '0;
            pad_uio_out <= '0;
            pad_uio_oe  <= '0;
        end else if (r_state == ST_ON) begin
            r_usr_iw    <= {pad_uio_in, pad_ui_in};
            pad_uo_out  <= w_usr_ow[0 +: N_O];
            pad_uio_out <= w_usr_ow[N_O +: N_IO];
            pad_uio_oe  <= w_usr_ow[N_O + N_IO +: N_IO];
        end else begin
            r_usr_iw    <= '0;
            pad_uo_out  <= '0;
            pad_uio_out <= '0;
            pad_uio_oe  <= '0;
        end
    end

    // User inputs are also gated by the live state so nothing leaks on exit.
    always_comb begin
        w_iw = '0;
        w_iw[c_iw_ena] = active;
        w_iw[c_iw_sel_lsb +: c_sel_w] = r_sel;
        w_iw[c_iw_usr_lsb +: c_usr_iw_w] = active ? r_usr_iw : '0;
    end

    assign spine.spine_iw = w_iw;

endmodule

`default_nettype wire
